// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  // Port 0 = instruction fetch, port 1 = data access
  typedef logic [0:0] port_idx_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction watchdog: saturating cycle counter with clear/enable and a sticky flag.
// Latency: flag registers on the edge where the count reaches TIMEOUT_CYCLES.
// Backpressure: none; TIMEOUT_CYCLES = 0 disables the flag entirely.
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_flag
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;
  logic          r_flag;

  // Count enabled cycles up to LIMIT; the flag survives clears and only reset drops it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
      if ((TIMEOUT_CYCLES > 0) && (r_count + 1'b1 == LIMIT)) begin
        r_flag <= 1'b1;
      end
    end
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (port 0) and data (port 1); optional MEM_ARB_ROUND_ROBIN_EN.
// Latency: strobe 1 cycle after request sampled in IDLE; 2 cycles overhead (IDLE sample + RECOVER) per transaction.
// Backpressure: requesters hold read/write until their resp pulse; the losing port simply waits in IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      p0_read,
  input  logic                      p0_write,
  input  logic [ADDR_WIDTH-1:0]     p0_addr,
  input  logic [DATA_WIDTH-1:0]     p0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   p0_byte_enable,
  output logic [DATA_WIDTH-1:0]     p0_rdata,
  output logic                      p0_resp,
  input  logic                      p1_read,
  input  logic                      p1_write,
  input  logic [ADDR_WIDTH-1:0]     p1_addr,
  input  logic [DATA_WIDTH-1:0]     p1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   p1_byte_enable,
  output logic [DATA_WIDTH-1:0]     p1_rdata,
  output logic                      p1_resp,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_resp,
  output logic                      timeout_err
);

  arb_state_t                r_state;
  port_idx_t                 r_grant;
  logic                      r_mem_read;
  logic                      r_mem_write;
  logic [ADDR_WIDTH-1:0]     r_mem_addr;
  logic [DATA_WIDTH-1:0]     r_mem_wdata;
  logic [DATA_WIDTH/8-1:0]   r_mem_be;

  logic                      w_p0_req;
  logic                      w_p1_req;
  logic                      w_any_req;
  port_idx_t                 w_win;
  logic                      w_sel_read;
  logic                      w_sel_write;
  logic [ADDR_WIDTH-1:0]     w_sel_addr;
  logic [DATA_WIDTH-1:0]     w_sel_wdata;
  logic [DATA_WIDTH/8-1:0]   w_sel_be;
  logic                      w_resp_fire;

  assign w_p0_req  = p0_read | p0_write;
  assign w_p1_req  = p1_read | p1_write;
  assign w_any_req = w_p0_req | w_p1_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_idx_t r_last_grant;
  // On contention hand the grant to whichever port did not win last time
  assign w_win = (w_p0_req && w_p1_req) ? ~r_last_grant : port_idx_t'(w_p1_req);
`else
  // Data port always wins contention
  assign w_win = port_idx_t'(w_p1_req);
`endif

  assign w_sel_read  = w_win[0] ? p1_read        : p0_read;
  assign w_sel_write = w_win[0] ? p1_write       : p0_write;
  assign w_sel_addr  = w_win[0] ? p1_addr        : p0_addr;
  assign w_sel_wdata = w_win[0] ? p1_wdata       : p0_wdata;
  assign w_sel_be    = w_win[0] ? p1_byte_enable : p0_byte_enable;

  // Arbitration FSM: latch winner in IDLE, hold mem_* through SERVE, one dead cycle in RECOVER
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant     <= w_win;
            r_mem_read  <= w_sel_read;
            // A port raising both read and write gets the read only
            r_mem_write <= w_sel_write & ~w_sel_read;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_be    <= w_sel_be;
            r_state     <= SERVE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_grant <= w_win;
`endif
          end
        end
        SERVE: begin
          if (mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= RECOVER;
          end
        end
        RECOVER: begin
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Completion is forwarded combinationally, and only while a transaction is outstanding
  assign w_resp_fire = (r_state == SERVE) & mem_resp;
  assign p0_resp     = w_resp_fire & (r_grant == 1'b0);
  assign p1_resp     = w_resp_fire & (r_grant == 1'b1);
  assign p0_rdata    = mem_rdata;
  assign p1_rdata    = mem_rdata;

  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign mem_byte_enable = r_mem_be;

  mem_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  ((r_state == IDLE) & w_any_req),
    .i_enable ((r_state == SERVE) & ~mem_resp),
    .o_flag   (timeout_err)
  );

endmodule
